// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port integer register file.
// Used by regfile_mp, regfile_mp_if and regfile_clear_fsm.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int unsigned RF_XLEN_DEFAULT  = 32;
    localparam int unsigned RF_NREGS_DEFAULT = 32;
    localparam int unsigned RF_ZERO_ADDR     = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write port bundle between decode/write-back and the register file.
// The parameters must match those of the regfile_mp instance it connects to.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = RF_XLEN_DEFAULT,
    parameter int unsigned NREGS = RF_NREGS_DEFAULT,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NWR-1:0]           we;
    logic [NWR-1:0][AW-1:0]   waddr;
    logic [NWR-1:0][XLEN-1:0] wdata;
    logic [NRD-1:0][AW-1:0]   raddr;
    logic [NRD-1:0][XLEN-1:0] rdata;
    logic                     ready;

    modport master (
        output we, waddr, wdata, raddr,
        input  rdata, ready
    );

    modport slave (
        input  we, waddr, wdata, raddr,
        output rdata, ready
    );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: sweeps registers 1..NREGS-1 to zero, then
// raises ready. A reset at any point restarts the sweep from register 1.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = RF_NREGS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     clr_en,
    output logic [$clog2(NREGS)-1:0] clr_addr,
    output logic                     ready
);
    localparam int unsigned AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] cnt_q,   cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear write is suppressed while reset is held so the sweep restarts cleanly.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_en   = 1'b0;
        clr_addr = cnt_q;
        ready    = (state_q == RF_RUN);
        case (state_q)
            RF_CLEAR: begin
                clr_en = !rst;
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = RF_RUN;
                end
            end
            RF_RUN: begin
                state_d = RF_RUN;
            end
            default: begin
                state_d = RF_CLEAR;
            end
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardware clear, write-port priority
// (highest index wins) and optional same-cycle bypass under REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = RF_XLEN_DEFAULT,
    parameter int unsigned NREGS = RF_NREGS_DEFAULT,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];

    logic            clr_en;
    logic [AW-1:0]   clr_addr;
    logic            ready;

    regfile_clear_fsm #(
        .NREGS (NREGS)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Clear sweep owns the array until ready; later write ports override earlier ones.
    always_comb begin
        mem_d = mem_q;
        if (!rst) begin
            if (clr_en) begin
                mem_d[clr_addr] = '0;
            end else if (ready) begin
                for (int unsigned i = 0; i < NWR; i++) begin
                    if (bus.we[i] && bus.waddr[i] != AW'(RF_ZERO_ADDR)) begin
                        mem_d[bus.waddr[i]] = bus.wdata[i];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < NRD; j++) begin
            bus.rdata[j] = '0;
            if (ready && bus.raddr[j] != AW'(RF_ZERO_ADDR)) begin
                bus.rdata[j] = mem_q[bus.raddr[j]];
`ifdef REGFILE_BYPASS_EN
                for (int unsigned i = 0; i < NWR; i++) begin
                    if (bus.we[i] && bus.waddr[i] == bus.raddr[j]) begin
                        bus.rdata[j] = bus.wdata[i];
                    end
                end
`endif
            end
        end
    end

    assign bus.ready = ready;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the 5-stage RISC-V pipeline, sitting between decode (reads) and write-back (writes). It generalises the single-write, two-read file to configurable width, depth, read-port count and write-port count. It adds:
- a hardware clear sequence after reset, with a `ready` indicator;
- deterministic write-port priority;
- optional same-cycle write-to-read bypass.

Register 0 is hardwired to zero.

## Interface
Parameters:
- `XLEN`, 32, register width in bits
- `NREGS`, 32, number of registers (power of two, ≥4)
- `NRD`, 2, number of read ports (1..4)
- `NWR`, 1, number of write ports (1..2)
- `AW`, `$clog2(NREGS)`, address width (derived, not overridden)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `we`  in  `NWR`  per-port write enable
- `waddr`  in  `NWR`×`AW`  per-port write address
- `wdata`  in  `NWR`×`XLEN`  per-port write data
- `raddr`  in  `NRD`×`AW`  per-port read address
- `rdata`  out  `NRD`×`XLEN`  per-port read data, combinational from `raddr`
- `ready`  out  1  high once the clear sequence has completed

## Operation
- State machine with two states: `CLEAR` and `RUN`.
- While `rst` is high at a rising edge:
  - state ← `CLEAR`
  - clear counter ← 1
  - `we` ignored
- In `CLEAR`, at each rising edge:
  - mem[counter] ← 0 and counter increments
  - when counter == `NREGS`-1 is cleared, state ← `RUN`
  - all `we` are ignored
- In `RUN`, at each rising edge, mem[`waddr`[i]] ← `wdata`[i] for each i with `we`[i]=1 and `waddr`[i]≠0.
- Writes to address 0 are dropped; mem[0] is never written and always reads 0.
- Write collision (`NWR`=2, both enabled, same address): port 1 wins and port 0's data is discarded.
- Reads are asynchronous: `rdata`[j] = mem[`raddr`[j]], forced to 0 when `raddr`[j]==0 or `ready`==0.
- `ready` = (state == `RUN`).
- Reset asserted mid-`CLEAR` restarts the sweep from register 1.
- Reset asserted in `RUN` discards any write presented in that cycle and re-enters `CLEAR`.
- Simulation content before the first reset is X; there is no file preload.

## Timing
- Reset values:
  - `ready`=0
  - `rdata`=0 on all ports while `ready`=0
  - state `CLEAR`, counter 1
- Clear latency: `ready` rises after exactly `NREGS`-1 rising edges with `rst` low (31 edges at default).
- Write latency: data written at rising edge N is visible on `rdata` after edge N, i.e. in cycle N+1. Without bypass there is no same-cycle visibility.
- Read latency: 0 cycles (combinational from `raddr` and current mem/bypass inputs).
- No handshake on writes; every enabled write in `RUN` completes in one cycle.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: in `RUN`, if `we`[i]=1, `waddr`[i]==`raddr`[j] and `raddr`[j]≠0, then `rdata`[j] = `wdata`[i] in the same cycle. With two matching writers, port 1's data is returned, consistent with write priority. Bypass is inactive while `ready`=0. This replaces the negedge-write trick for write-back/decode forwarding.
- Undefined: no forwarding; a read of an address being written returns the old contents until the next cycle.

## Structure
- Package `regfile_pkg` contains:
  - the state enum `rf_state_e` {`RF_CLEAR`, `RF_RUN`}
  - default `XLEN`/`NREGS` localparams
  - the `RF_ZERO_ADDR` constant (0)
- Sub-module `regfile_clear_fsm` holds the state register and clear counter.
  - Inputs: `clk`, `rst`.
  - Outputs: `clr_en`, `clr_addr`, `ready`.
  - The top module muxes the clear write against the normal write ports.
- Storage, write priority, read muxes and the bypass live in `regfile_mp`.

## Test plan
- Reset and clear: assert `rst` 3 cycles, release, and count edges. `ready`=0 for 31 edges, then 1. All 32 registers then read 0 on every port.
- Reset mid-clear: release `rst`, re-assert it after 10 edges, then release again. `ready` rises exactly 31 edges after the second release.
- Basic write/read: write x5←0xDEADBEEF. The next cycle, `raddr`=5 on both ports returns 0xDEADBEEF. A write to x0 of 0x1234 still reads 0.
- Collision (`NWR`=2): port 0 writes x7←0x11111111 and port 1 writes x7←0x22222222 in the same cycle. x7 then reads 0x22222222.
- Bypass: write x9←0xCAFEF00D with `raddr`[0]=9 in the same cycle.
  - With `REGFILE_BYPASS_EN` defined, `rdata`[0]=0xCAFEF00D in that cycle.
  - Without it, `rdata`[0] returns the old x9 value that cycle and 0xCAFEF00D the next.
- Writes during clear: assert `we` with x3←0xFFFFFFFF while `ready`=0. After `ready` rises, x3 reads 0.
